// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-serial memory initiator.
package mem_pkg;

   localparam int ADDR_W = 8;
   localparam int BUS_W  = 8;
   localparam int WORD_W = 32;

   localparam logic [2:0] BEATS_BYTE = 3'd1;
   localparam logic [2:0] BEATS_WORD = 3'd4;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } state_t;

   // Little-endian byte lane of a word.
   function automatic logic [BUS_W-1:0] word_lane(input logic [WORD_W-1:0] w,
                                                  input logic [1:0] idx);
      logic [BUS_W-1:0] b;
      case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

endpackage

// File: rtl/mem_bus_drv.sv
// Tri-state driver for the shared memory data bus and the read-capture word.
module mem_bus_drv
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              oe,
   input  logic [BUS_W-1:0]  dout,
   inout  wire  [BUS_W-1:0]  bus,
   input  logic              cap_clr,
   input  logic              cap_en,
   input  logic [1:0]        cap_lane,
   output logic [WORD_W-1:0] cap_next
);

   logic [WORD_W-1:0] cap_q;

   assign bus = oe ? dout : {BUS_W{1'bz}};

   // cap_next folds in the byte on the bus this cycle so the last beat
   // can be returned on the same edge it is captured.
   always_comb begin
      cap_next = cap_q;
      if (cap_en)
         cap_next[{cap_lane, 3'b000} +: BUS_W] = bus;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cap_q <= '0;
      else if (cap_clr)
         cap_q <= '0;
      else
         cap_q <= cap_next;
   end

endmodule

// File: rtl/mem_master.sv
// Sequences CPU byte/word loads and stores into byte beats on the 8-bit memory bus.
module mem_master
   import mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_word,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [WORD_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [WORD_W-1:0] rsp_rdata,
   output logic              mem_R,
   output logic              mem_W,
   output logic [ADDR_W-1:0] mem_add,
   inout  wire  [BUS_W-1:0]  mem_data
);

   state_t            state, state_n;
   logic              word_q;
   logic [ADDR_W-1:0] addr_q;
   logic [WORD_W-1:0] wdata_q;
   logic [2:0]        cnt, cnt_n, cnt_inc, beats;
   logic [ADDR_W-1:0] add_n;
   logic [BUS_W-1:0]  dout, dout_n;
   logic              r_n, w_n, rsp_n;
   logic              cap_en, cap_clr, rdata_ld;
   logic [1:0]        cap_lane;
   logic [WORD_W-1:0] cap_next;

   assign req_ready = (state == IDLE);
   assign beats     = word_q ? BEATS_WORD : BEATS_BYTE;
   assign cnt_inc   = cnt + 3'd1;
   // Read data lags the address by one cycle, so cycle c captures lane c-1.
   assign cap_lane  = cnt[1:0] - 2'd1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      add_n    = mem_add;
      dout_n   = dout;
      r_n      = 1'b0;
      w_n      = 1'b0;
      rsp_n    = 1'b0;
      cap_en   = 1'b0;
      cap_clr  = 1'b0;
      rdata_ld = 1'b0;
      case (state)
         IDLE: begin
            if (req_valid) begin
               cnt_n   = '0;
               add_n   = req_addr;
               cap_clr = 1'b1;
               if (req_we) begin
                  state_n = WRITE;
                  w_n     = 1'b1;
                  dout_n  = word_lane(req_wdata, 2'd0);
               end else begin
                  state_n = READ;
                  r_n     = 1'b1;
               end
            end
         end
         READ: begin
            cap_en = (cnt != 3'd0);
            if (cnt == beats) begin
               state_n  = RESP;
               rsp_n    = 1'b1;
               rdata_ld = 1'b1;
            end else begin
               r_n   = 1'b1;
               cnt_n = cnt_inc;
               // The extra trailing cycle holds the last beat address.
               if (cnt_inc < beats)
                  add_n = addr_q + {5'd0, cnt_inc};
            end
         end
         WRITE: begin
            if (cnt_inc == beats) begin
               state_n = RESP;
               rsp_n   = 1'b1;
            end else begin
               w_n    = 1'b1;
               cnt_n  = cnt_inc;
               add_n  = addr_q + {5'd0, cnt_inc};
               dout_n = word_lane(wdata_q, cnt_inc[1:0]);
            end
         end
         RESP:    state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_q    <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt       <= '0;
         mem_R     <= 1'b0;
         mem_W     <= 1'b0;
         mem_add   <= '0;
         dout      <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else begin
         if (state == IDLE && req_valid) begin
            word_q  <= req_word;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
         cnt       <= cnt_n;
         mem_R     <= r_n;
         mem_W     <= w_n;
         mem_add   <= add_n;
         dout      <= dout_n;
         rsp_valid <= rsp_n;
         if (rdata_ld)
            rsp_rdata <= word_q ? cap_next : {24'd0, cap_next[7:0]};
      end
   end

   mem_bus_drv u_bus (
      .clk      (clk),
      .rst      (rst),
      .oe       (mem_W & ~mem_R),
      .dout     (dout),
      .bus      (mem_data),
      .cap_clr  (cap_clr),
      .cap_en   (cap_en),
      .cap_lane (cap_lane),
      .cap_next (cap_next)
   );

endmodule

// File: tb/tb_mem_master.sv
// Scoreboard bench for mem_master with a registered-read memory model on the bus.
module tb_mem_master;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0;
   logic        req_we = 1'b0;
   logic        req_word = 1'b0;
   logic [7:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   wire         req_ready, rsp_valid, mem_R, mem_W;
   wire  [31:0] rsp_rdata;
   wire  [7:0]  mem_add;
   wire  [7:0]  mem_data;

   always #5 clk = ~clk;

   mem_master dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_word(req_word), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .mem_R(mem_R), .mem_W(mem_W), .mem_add(mem_add), .mem_data(mem_data)
   );

   typedef struct {
      logic        we;
      logic        word;
      logic [7:0]  addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] old;
      int          acc;
   } exp_t;

   exp_t        q[$];
   int          checks = 0, errors = 0, cyc = 0;
   int          r_cnt = 0, w_cnt = 0;
   logic [31:0] last_rd = '0;
   logic [7:0]  smem[256];
   logic [7:0]  shadow[256];
   logic [7:0]  s_q = '0;
   logic        s_oe = 1'b0;
   logic        mem_init = 1'b1;

   function automatic logic [7:0] pat(input int i);
      return 8'(i * 7 + 3);
   endfunction

   function automatic logic [7:0] lane(input logic [31:0] w, input int i);
      return 8'(w >> (8 * i));
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
      end
   endtask

   // Memory: registered read, drives the bus in the cycle after a read strobe.
   always @(posedge clk) begin
      if (mem_init)
         for (int i = 0; i < 256; i++) smem[i] <= pat(i);
      else if (mem_W)
         smem[mem_add] <= mem_data;
      s_oe <= mem_R;
      s_q  <= smem[mem_add];
   end
   assign mem_data = s_oe ? s_q : 8'hzz;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor / scoreboard.
   always @(negedge clk) begin : mon
      exp_t e, e2;
      int   n, n2, lat;
      logic [7:0] a;
      if (mem_init)
         for (int i = 0; i < 256; i++) shadow[i] = pat(i);
      if (rst) begin
         // Abandoned store: beats already on the bus stick, the rest never happened.
         if (q.size() != 0 && q[0].we)
            for (int i = w_cnt; i < (q[0].word ? 4 : 1); i++)
               shadow[8'(q[0].addr + 8'(i))] = lane(q[0].old, i);
         q.delete();
         r_cnt = 0; w_cnt = 0; last_rd = '0;
      end else begin
         if (q.size() != 0) begin
            e = q[0];
            n = e.word ? 4 : 1;
            check("ready_busy", 32'(req_ready), 32'd0);
            check("strobe_excl", 32'(mem_R & mem_W), 32'd0);
            check("bus_contention", 32'(s_oe & mem_W & ~mem_R), 32'd0);
            if (mem_R) begin
               check("rd_addr", 32'(mem_add), 32'(8'(e.addr + 8'((r_cnt < n) ? r_cnt : n - 1))));
               r_cnt++;
            end
            if (mem_W) begin
               check("wr_addr", 32'(mem_add), 32'(8'(e.addr + 8'(w_cnt))));
               check("wr_data", 32'(mem_data), 32'(lane(e.wdata, w_cnt)));
               w_cnt++;
            end
            if (rsp_valid) begin
               lat = e.we ? (e.word ? 4 : 1) : (e.word ? 5 : 2);
               check("rsp_latency", cyc - e.acc, lat);
               check("rd_beats", r_cnt, e.we ? 0 : n + 1);
               check("wr_beats", w_cnt, e.we ? n : 0);
               if (!e.we) last_rd = e.rdata;
               check("rsp_rdata", rsp_rdata, last_rd);
               void'(q.pop_front());
               r_cnt = 0; w_cnt = 0;
            end else if (cyc - e.acc > 8) begin
               check("rsp_timeout", 32'(rsp_valid), 32'd1);
               void'(q.pop_front());
               r_cnt = 0; w_cnt = 0;
            end
         end else begin
            check("idle_quiet", 32'({mem_R, mem_W, rsp_valid}), 32'd0);
         end
         if (req_valid && req_ready) begin
            check("one_outstanding", q.size(), 0);
            e2.we = req_we; e2.word = req_word; e2.addr = req_addr;
            e2.wdata = req_wdata; e2.rdata = '0; e2.old = '0; e2.acc = cyc + 1;
            n2 = req_word ? 4 : 1;
            for (int i = 0; i < n2; i++) begin
               a = 8'(req_addr + 8'(i));
               e2.old = e2.old | (32'(shadow[a]) << (8 * i));
               if (req_we) shadow[a] = lane(req_wdata, i);
               else        e2.rdata = e2.rdata | (32'(shadow[a]) << (8 * i));
            end
            q.push_back(e2);
         end
      end
   end

   task automatic issue(input logic we, input logic word, input logic [7:0] a, input logic [31:0] d);
      int budget = 50;
      @(posedge clk); #1;
      req_valid = 1'b1; req_we = we; req_word = word; req_addr = a; req_wdata = d;
      @(negedge clk);
      while (!req_ready && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("accept_wait", 32'(req_ready), 32'd1);
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int budget = 100;
      @(negedge clk);
      while ((q.size() != 0 || !req_ready) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("drain_wait", 32'(q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      @(posedge clk); @(posedge clk); #1;
      mem_init = 1'b0;
      check("rst_req_ready", 32'(req_ready), 32'd1);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      check("rst_mem_R", 32'(mem_R), 32'd0);
      check("rst_mem_W", 32'(mem_W), 32'd0);
      check("rst_mem_add", 32'(mem_add), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Byte store then byte load.
      issue(1'b1, 1'b0, 8'h10, 32'hFFFF_FFA5);
      issue(1'b0, 1'b0, 8'h10, 32'h0);
      wait_idle();
      check("byte_load_val", rsp_rdata, 32'h0000_00A5);

      // Word store / load, little-endian layout.
      issue(1'b1, 1'b1, 8'h20, 32'h1234_5678);
      wait_idle();
      check("mem20", 32'(smem[8'h20]), 32'h78);
      check("mem21", 32'(smem[8'h21]), 32'h56);
      check("mem22", 32'(smem[8'h22]), 32'h34);
      check("mem23", 32'(smem[8'h23]), 32'h12);
      issue(1'b0, 1'b1, 8'h20, 32'h0);
      wait_idle();
      check("word_load_val", rsp_rdata, 32'h1234_5678);

      // Address wrap past 0xFF.
      issue(1'b1, 1'b1, 8'hFE, 32'hDEAD_BEEF);
      wait_idle();
      check("memFE", 32'(smem[8'hFE]), 32'hEF);
      check("memFF", 32'(smem[8'hFF]), 32'hBE);
      check("mem00", 32'(smem[8'h00]), 32'hAD);
      check("mem01", 32'(smem[8'h01]), 32'hDE);
      issue(1'b0, 1'b1, 8'hFE, 32'h0);
      wait_idle();
      check("wrap_load_val", rsp_rdata, 32'hDEAD_BEEF);

      // Load right after a store.
      issue(1'b1, 1'b1, 8'h50, 32'hCAFE_F00D);
      issue(1'b0, 1'b1, 8'h50, 32'h0);
      issue(1'b1, 1'b0, 8'h51, 32'h0000_0077);
      issue(1'b0, 1'b0, 8'h51, 32'h0);
      wait_idle();

      // req_valid held high with fields changing every cycle.
      @(posedge clk); #1;
      req_valid = 1'b1;
      repeat (80) begin
         req_we    = 1'($urandom);
         req_word  = 1'($urandom);
         req_addr  = ($urandom_range(0, 1) != 0) ? 8'(8'hFC + $urandom_range(0, 3))
                                                 : 8'(8'h30 + $urandom_range(0, 7));
         req_wdata = $urandom;
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      wait_idle();

      // Reset during beat 2 of a word store.
      issue(1'b1, 1'b1, 8'h40, 32'hDDCC_BBAA);
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("abort_mem_R", 32'(mem_R), 32'd0);
      check("abort_mem_W", 32'(mem_W), 32'd0);
      check("abort_rsp", 32'(rsp_valid), 32'd0);
      check("abort_ready", 32'(req_ready), 32'd1);
      repeat (3) begin
         @(negedge clk);
         check("abort_no_rsp", 32'(rsp_valid), 32'd0);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_m40", 32'(smem[8'h40]), 32'hAA);
      check("abort_m41", 32'(smem[8'h41]), 32'hBB);
      check("abort_m42", 32'(smem[8'h42]), 32'(pat(8'h42)));
      check("abort_m43", 32'(smem[8'h43]), 32'(pat(8'h43)));
      issue(1'b0, 1'b1, 8'h40, 32'h0);
      wait_idle();
      check("abort_load_val", rsp_rdata, {pat(8'h43), pat(8'h42), 8'hBB, 8'hAA});

      // Random requests with random gaps.
      repeat (40) begin
         issue(1'($urandom), 1'($urandom), 8'($urandom_range(0, 15) + 8'hF8), $urandom);
         repeat ($urandom_range(0, 2)) @(posedge clk);
      end
      wait_idle();
      for (int i = 0; i < 256; i++)
         if (smem[i] !== shadow[i]) check("final_mem", 32'(smem[i]), 32'(shadow[i]));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
